md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit with HI/LO registers, sitting beside the ALU in the EX stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo, holds a busy flag for a configurable latency, and commits results to HI/LO. The hazard unit reads `busy` to stall any HI/LO-touching instruction in D. Width and latencies are parameters so the same block serves later core generations.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu. Must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu. Must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  op valid in EX this cycle. The pipeline drives it low on bubbles.
- `op`  in  3  operation code from `md_pkg`: MULT, MULTU, DIV, DIVU, MTHI, MTLO. Other codes are no-ops.
- `a`  in  WIDTH  rs operand, already forwarded.
- `b`  in  WIDTH  rt operand, already forwarded.
- `busy`  out  1  long operation in flight. Reset value 0.
- `done`  out  1  high during the final busy cycle. Reset value 0.
- `hi`  out  WIDTH  HI register. Reset value 0.
- `lo`  out  WIDTH  LO register. Reset value 0.

## Operation
- States: IDLE, RUN. `busy` = (state == RUN). `done` = RUN & (cnt == 1).
- In IDLE, with `start` sampled high at a rising edge:
  - MULT/MULTU: capture the 2·WIDTH product {H,L} into pending registers. Load `cnt` = MULT_CYCLES. Go to RUN.
  - DIV/DIVU: capture pending (rem, quot). Load `cnt` = DIV_CYCLES. Go to RUN.
  - MTHI/MTLO: `hi` (resp. `lo`) ← `a` at that same edge. State stays IDLE. The other register is untouched.
- In RUN, each edge decrements `cnt`. At the edge where `cnt == 1`: `hi` ← pending high, `lo` ← pending low, state → IDLE.
- `start` while RUN, any op: ignored. The hazard unit guarantees this never occurs. The bench checks that HI/LO and `cnt` are undisturbed.
- Signed mult: two's-complement full product. Unsigned mult: zero-extended.
- Signed div:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - INT_MIN / −1 gives `lo` = INT_MIN, `hi` = 0.
- Unsigned div: plain.
- Divide by zero, either sign: the unit still runs DIV_CYCLES busy cycles. HI/LO keep their old values at commit (no write). `done` still pulses.
- Reset low at any time, including mid-RUN: immediately go to IDLE, clear `cnt`, `hi`, `lo` and pending, and drop `busy`/`done`. Reset dominates `start`.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Timing
- Start accepted at edge k. `busy` is high in cycles k+1 … k+L, where L is the op's latency. `done` is high in cycle k+L.
- New `hi`/`lo` are visible from cycle k+L+1.
- A back-to-back start in cycle k+L+1 is accepted. Start in cycle k+L is ignored, because the unit is still RUN.
- MTHI/MTLO: new value visible in the cycle after the edge. `busy` is never asserted.
- The `hi`/`lo` outputs are registers with no combinational path from inputs. `busy` and `done` decode registered state only.
- Hazard rule owned by the core: stall D when `busy`, or when `start` & op is MULT*/DIV*, and the D instruction uses HI/LO.

## Structure
- `md_pkg` holds the op encoding enum/constants and the `MD_NOP` default.
- `md_unit` holds the FSM, counter, pending registers and HI/LO.
- One combinational sub-module, `md_arith`, computes the product, quotient and remainder (signed and unsigned) plus the div-by-zero and overflow flags. It is instanced once.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → busy for 5 cycles, done in the 5th; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7, b=2 → busy for 10 cycles; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=2 → lo=3, hi=1.
- Divide by zero: first MTHI 0x11, MTLO 0x22, then DIV a=5, b=0 → busy for 10 cycles, done pulses; hi=0x11 and lo=0x22 are unchanged.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT issued, then a MTLO start plus a second MULT start in busy cycle 3 → both are ignored; the final lo is the first product's low word. A start in cycle k+L+1 is accepted.
- Reset pulled low in busy cycle 2 of a DIV → busy, done, hi and lo are 0 immediately. After release, no commit occurs.
- Parameter sweep WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=1: MULT 0x8000×0x0002 → busy for 1 cycle, done in that cycle; hi=0xFFFF, lo=0x0000.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and a
// small constant helper used to size the latency counter.
package md_pkg;

    // Op codes driven by the decoder; any unlisted code behaves as a no-op.
    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Purely combinational arithmetic core: signed/unsigned full products and
// signed/unsigned quotient/remainder, plus divide-by-zero and overflow flags.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_s_o,
    output logic [2*WIDTH-1:0] prod_u_o,
    output logic [WIDTH-1:0]   quot_s_o,
    output logic [WIDTH-1:0]   rem_s_o,
    output logic [WIDTH-1:0]   quot_u_o,
    output logic [WIDTH-1:0]   rem_u_o,
    output logic               div_zero_o,
    output logic               div_ovf_o
);

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, b_mag_safe, q_mag, r_mag;

    // Extending to 2*WIDTH first makes the low 2*WIDTH bits of a plain
    // multiply equal to the exact signed (or unsigned) product.
    assign a_sx     = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_sx     = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign a_zx     = {{WIDTH{1'b0}}, a_i};
    assign b_zx     = {{WIDTH{1'b0}}, b_i};
    assign prod_s_o = a_sx * b_sx;
    assign prod_u_o = a_zx * b_zx;

    assign div_zero_o = (b_i == '0);
    assign div_ovf_o  = (a_i == INT_MIN) && (b_i == '1);

    // Signed division is done on magnitudes so the operator never sees a
    // signed overflow; a zero divisor is swapped for 1 and the result is
    // discarded by the caller.
    assign a_neg      = a_i[WIDTH-1];
    assign b_neg      = b_i[WIDTH-1];
    assign a_mag      = a_neg ? -a_i : a_i;
    assign b_mag      = b_neg ? -b_i : b_i;
    assign b_safe     = div_zero_o ? ONE : b_i;
    assign b_mag_safe = div_zero_o ? ONE : b_mag;

    assign quot_u_o = a_i / b_safe;
    assign rem_u_o  = a_i % b_safe;
    assign q_mag    = a_mag / b_mag_safe;
    assign r_mag    = a_mag % b_mag_safe;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quot_s_o = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem_s_o  = a_neg ? -r_mag : r_mag;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage. Results are
// computed at issue, parked in pending registers, and committed to HI/LO
// after a fixed per-op busy latency.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic             launch;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
    logic               div_zero, div_ovf;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .a_i        (a),
        .b_i        (b),
        .prod_s_o   (prod_s),
        .prod_u_o   (prod_u),
        .quot_s_o   (quot_s),
        .rem_s_o    (rem_s),
        .quot_u_o   (quot_u),
        .rem_u_o    (rem_u),
        .div_zero_o (div_zero),
        .div_ovf_o  (div_ovf)
    );

    // Select what a long op would park in the pending registers, and its latency.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        pend_hi_d = '0;
        pend_lo_d = '0;
        pend_wr_d = 1'b0;
        cnt_d     = '0;
        launch    = 1'b0;
        case (op)
            MD_MULT: begin
                {pend_hi_d, pend_lo_d} = prod_s;
                pend_wr_d = 1'b1;
                cnt_d     = MULT_LOAD;
                launch    = 1'b1;
            end
            MD_MULTU: begin
                {pend_hi_d, pend_lo_d} = prod_u;
                pend_wr_d = 1'b1;
                cnt_d     = MULT_LOAD;
                launch    = 1'b1;
            end
            MD_DIV: begin
                pend_hi_d = div_ovf ? '0 : rem_s;
                pend_lo_d = div_ovf ? INT_MIN : quot_s;
                pend_wr_d = !div_zero;
                cnt_d     = DIV_LOAD;
                launch    = 1'b1;
            end
            MD_DIVU: begin
                pend_hi_d = rem_u;
                pend_lo_d = quot_u;
                pend_wr_d = !div_zero;
                cnt_d     = DIV_LOAD;
                launch    = 1'b1;
            end
            default: ;
        endcase
    end

    // IDLE/RUN sequencer: issue, count down, commit; direct HI/LO moves in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            // NOTE: the pending registers are cleared too, so an aborted op
            // can never leak a stale result into HI/LO.
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (launch) begin
                            pend_hi_q <= pend_hi_d;
                            pend_lo_q <= pend_lo_d;
                            pend_wr_q <= pend_wr_d;
                            cnt_q     <= cnt_d;
                            state_q   <= ST_RUN;
                        end else if (op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (op == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = busy && (cnt_q == CNT_ONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, multi-cycle corner
// sequences, a narrow/short-latency instance, and random ops against a model.
module tb_md_unit;
    import md_pkg::*;

    localparam int LAT_MULT = 5;
    localparam int LAT_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] hi16, lo16;

    int total = 0;
    int bad   = 0;
    logic [31:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_CYCLES(LAT_MULT), .DIV_CYCLES(LAT_DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.name = n; v.op = o; v.a = x; v.b = y; v.eh = eh; v.el = el;
        vecs.push_back(v);
    endtask

    function automatic int lat_of(input logic [2:0] o);
        if (o == MD_MULT || o == MD_MULTU) return LAT_MULT;
        if (o == MD_DIV || o == MD_DIVU) return LAT_DIV;
        return 0;
    endfunction

    // Reference behaviour written with 64-bit integer arithmetic.
    task automatic model_step(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              inout logic [31:0] h, inout logic [31:0] l);
        longint          sx, sy, p, q, r;
        longint unsigned ux, uy, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            MD_MULT:  begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            MD_MULTU: begin pu = ux * uy; h = pu[63:32]; l = pu[31:0]; end
            MD_DIV:   if (y != 0) begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
            MD_DIVU:  if (y != 0) begin l = x / y; h = x % y; end
            MD_MTHI:  h = x;
            MD_MTLO:  l = x;
            default:  ;
        endcase
    endtask

    // Issue one op in the current cycle, check the busy window, then the result.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int l;
        l = lat_of(o);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = MD_NOP;
        for (int i = 1; i <= l; i++) begin
            check({name, " busy"}, 64'(busy), 64'd1);
            check({name, " done"}, 64'(done), 64'(i == l));
            check({name, " hold"}, {hi, lo}, {cur_hi, cur_lo});
            @(negedge clk);
        end
        check({name, " idle"}, {62'd0, busy, done}, 64'd0);
        check({name, " hilo"}, {hi, lo}, {eh, el});
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_hi, m_lo, ra, rb;
        logic [2:0]  rop;

        reset = 1'b0; start = 1'b0; op = MD_NOP; a = '0; b = '0;
        start16 = 1'b0; op16 = MD_NOP; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("reset state", {busy, done, hi, lo[29:0]}, 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset16 state", {30'd0, busy16, done16, hi16, lo16}, 64'd0);
        reset = 1'b1;
        cur_hi = '0; cur_lo = '0;
        @(negedge clk);

        // Directed vectors, issued back to back.
        add_vec("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        add_vec("multu",     MD_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA);
        add_vec("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add_vec("divu",      MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3);
        add_vec("mthi",      MD_MTHI,  32'h11,        32'd0,        32'h11,        32'd3);
        add_vec("mtlo",      MD_MTLO,  32'h22,        32'd0,        32'h11,        32'h22);
        add_vec("div_zero",  MD_DIV,   32'd5,         32'd0,        32'h11,        32'h22);
        add_vec("divu_zero", MD_DIVU,  32'd5,         32'd0,        32'h11,        32'h22);
        add_vec("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        add_vec("div_pos_n", MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD);
        add_vec("nop0",      3'd0,     32'h55,        32'h66,       32'd1,         32'hFFFF_FFFD);
        add_vec("nop7",      3'd7,     32'h55,        32'h66,       32'd1,         32'hFFFF_FFFD);
        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

        // Starts arriving while RUN (cycles 3, 4 and the done cycle) are ignored.
        start = 1'b1; op = MD_MULT; a = 32'h1234; b = 32'h10;
        @(negedge clk);
        start = 1'b0; op = MD_NOP;
        for (int i = 1; i <= LAT_MULT; i++) begin
            check("ign busy", 64'(busy), 64'd1);
            check("ign done", 64'(done), 64'(i == LAT_MULT));
            check("ign hold", {hi, lo}, {cur_hi, cur_lo});
            case (i)
                3: begin start = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF; end
                4: begin start = 1'b1; op = MD_MULT; a = 32'hFFFF_FFFF; b = 32'd7; end
                5: begin start = 1'b1; op = MD_DIV;  a = 32'd9; b = 32'd2; end
                default: begin start = 1'b0; op = MD_NOP; end
            endcase
            @(negedge clk);
        end
        start = 1'b0; op = MD_NOP;
        check("ign idle", 64'(busy), 64'd0);
        check("ign result", {hi, lo}, {32'd0, 32'h0001_2340});
        cur_hi = 32'd0; cur_lo = 32'h0001_2340;
        run_op("back2back", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        // Reset in busy cycle 2 of a DIV aborts it with no later commit.
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = MD_NOP;
        @(negedge clk);
        check("rst pre busy", 64'(busy), 64'd1);
        #1 reset = 1'b0;
        #1 check("rst immediate", {busy, done, hi, lo[29:0]}, 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        start = 1'b1; op = MD_MTHI; a = 32'h55;
        @(negedge clk);
        start = 1'b0; op = MD_NOP;
        reset = 1'b1;
        for (int i = 0; i < LAT_DIV + 2; i++) begin
            check("rst no busy", 64'(busy), 64'd0);
            @(negedge clk);
        end
        check("rst no commit", {hi, lo}, 64'd0);
        cur_hi = '0; cur_lo = '0;

        // Narrow instance with single-cycle latencies.
        start16 = 1'b1; op16 = MD_MULT; a16 = 16'h8000; b16 = 16'h0002;
        @(negedge clk);
        start16 = 1'b0; op16 = MD_NOP;
        check("w16 mult busy", {busy16, done16}, 64'd3);
        @(negedge clk);
        check("w16 mult idle", 64'(busy16), 64'd0);
        check("w16 mult hilo", {hi16, lo16}, {16'hFFFF, 16'h0000});
        start16 = 1'b1; op16 = MD_DIV; a16 = 16'h8000; b16 = 16'hFFFF;
        @(negedge clk);
        start16 = 1'b1; op16 = MD_DIVU; a16 = 16'h8000; b16 = 16'd3;
        check("w16 div busy", {busy16, done16}, 64'd3);
        @(negedge clk);
        start16 = 1'b0; op16 = MD_NOP;
        check("w16 div ovf", {hi16, lo16}, {16'h0000, 16'h8000});
        @(negedge clk);
        check("w16 b2b ignored", {busy16, hi16, lo16}, {1'b0, 16'h0000, 16'h8000});

        // Random ops, with operand corner cases mixed in, against the model.
        m_hi = cur_hi; m_lo = cur_lo;
        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: begin ra = 32'h8000_0000; rb = '1; end
                3: ra = 32'h8000_0000;
                4: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            model_step(rop, ra, rb, m_hi, m_lo);
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, m_hi, m_lo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
